// File: rtl/coef_load_ctrl_pkg.sv
// Shared types and defaults for the UART-driven FIR coefficient loader.
// The byte tag occupies bits [TAG_MSB:TAG_LSB] of every high byte.
package coef_load_pkg;

    localparam int N_COEF_DEF      = 16;
    localparam int COEF_W_DEF      = 12;
    localparam int TIMEOUT_CYC_DEF = 1_000_000;
    localparam int ADDR_W          = 4;
    localparam int TAG_MSB         = 7;
    localparam int TAG_LSB         = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    function automatic logic [ADDR_W-1:0] tagOf(input logic [7:0] rxByte);
        return rxByte[TAG_MSB:TAG_LSB];
    endfunction

endpackage

// File: rtl/coef_load_ctrl_if.sv
// Byte stream from the UART receiver plus the indexed write port into the coefficient bank.
// The master modport is the loader side; the slave side is the UART/bank environment.
interface coef_load_ctrl_if
    import coef_load_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF
);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              coef_wr;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_data;

    modport master (
        input  rx_data,
        input  rx_valid,
        output coef_wr,
        output coef_addr,
        output coef_data
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  coef_wr,
        input  coef_addr,
        input  coef_data
    );

endinterface

// File: rtl/coef_load_ctrl_byte_timeout.sv
// Loadable down-counter that flags TIMEOUT_CYC consecutive running cycles without a clear.
// It expires during the last allowed cycle so that a byte in that cycle can still win.
module byte_timeout #(
    parameter int TIMEOUT_CYC = coef_load_pkg::TIMEOUT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD_VAL;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/coef_load_ctrl.sv
// Assembles COEF_W-bit coefficients from tagged UART byte pairs and writes them into the bank.
// The FIR enable is only raised after every coefficient of a load has been written.
module coef_load_ctrl
    import coef_load_pkg::*;
#(
    parameter int N_COEF      = N_COEF_DEF,
    parameter int COEF_W      = COEF_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    coef_load_ctrl_if.master bus,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             en_fir_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_COEF - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        coefLo_q, coefLo_d;
    logic [COEF_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              enFir_q, enFir_d;
    logic              tmrClear, tmrRun, tmrExpired;

    byte_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (tmrClear),
        .run_i    (tmrRun),
        .expired_o(tmrExpired)
    );

    // The timer is held loaded outside the wait states so each wait starts with a full budget.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        addr_d   = addr_q;
        coefLo_d = coefLo_q;
        data_d   = data_q;
        err_d    = err_q;
        enFir_d  = enFir_q;
        tmrClear = 1'b1;
        tmrRun   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_WAIT_LO;
                    index_d = '0;
                    err_d   = 1'b0;
                    enFir_d = 1'b0;
                end
            end
            S_WAIT_LO: begin
                tmrRun   = 1'b1;
                tmrClear = bus.rx_valid;
                if (bus.rx_valid) begin
                    coefLo_d = bus.rx_data;
                    state_d  = S_WAIT_HI;
                end else if (tmrExpired) begin
                    state_d = S_ERR;
                end
            end
            S_WAIT_HI: begin
                tmrRun   = 1'b1;
                tmrClear = bus.rx_valid;
                if (bus.rx_valid) begin
                    if (tagOf(bus.rx_data) == index_q) begin
                        addr_d  = index_q;
                        data_d  = {bus.rx_data[COEF_W-9:0], coefLo_q};
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (tmrExpired) begin
                    state_d = S_ERR;
                end
            end
            S_WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                    state_d = S_WAIT_LO;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Flags are set on entry so they rise together with done_o / the ERR cycle.
        if (state_d == S_DONE) begin
            enFir_d = 1'b1;
        end
        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            addr_q   <= '0;
            coefLo_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            enFir_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            addr_q   <= addr_d;
            coefLo_q <= coefLo_d;
            data_q   <= data_d;
            err_q    <= err_d;
            enFir_q  <= enFir_d;
        end
    end

    assign bus.coef_wr   = (state_q == S_WRITE);
    assign bus.coef_addr = addr_q;
    assign bus.coef_data = data_q;
    assign busy_o        = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI) || (state_q == S_WRITE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign en_fir_o      = enFir_q;

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Directed/random bench for coef_load_ctrl; expected writes come from a byte-pair model of the load protocol.
// TIMEOUT_CYC is shortened to 50 so the timeout boundary is reachable quickly.
module tb_coef_load_ctrl;
    import coef_load_pkg::*;

    localparam int TB_TIMEOUT = 50;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, err, enFir;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    wr_t        wrQ[$];
    int         doneQ[$];
    int         hiCyc[$];
    logic [7:0] loadBytes[$];
    int         errRise = -1;
    logic       errPrev = 1'b0;
    logic       watchIdle = 1'b0;
    int         nonZeroCnt = 0;

    coef_load_ctrl_if #(.COEF_W(12)) bus ();

    coef_load_ctrl #(
        .N_COEF     (16),
        .COEF_W     (12),
        .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .bus     (bus),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err),
        .en_fir_o(enFir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.coef_wr === 1'b1) wrQ.push_back('{addr: int'(bus.coef_addr), data: int'(bus.coef_data), cyc: cyc});
        if (done === 1'b1) doneQ.push_back(cyc);
        if (err === 1'b1 && errPrev !== 1'b1) errRise = cyc;
        errPrev = err;
        if (watchIdle && ((bus.coef_wr | busy | done | err | enFir) !== 1'b0 ||
                          bus.coef_addr !== '0 || bus.coef_data !== '0)) nonZeroCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic v, input logic [7:0] d);
        start        = st;
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        #1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " wr"}, 32'(bus.coef_wr), 0);
        checkOutput({tag, " addr"}, 32'(bus.coef_addr), 0);
        checkOutput({tag, " data"}, 32'(bus.coef_data), 0);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " done"}, 32'(done), 0);
        checkOutput({tag, " err"}, 32'(err), 0);
        checkOutput({tag, " en_fir"}, 32'(enFir), 0);
    endtask

    // Byte list: nGood correctly tagged pairs, then optionally one pair carrying a wrong tag.
    task automatic buildLoad(input int nGood, input bit patterned, input int badTag);
        loadBytes.delete();
        for (int k = 0; k < nGood; k++) begin
            logic [7:0] lo, hi;
            lo = patterned ? 8'(k) : 8'($urandom_range(0, 255));
            hi = {4'(k), patterned ? 4'(k) : 4'($urandom_range(0, 15))};
            loadBytes.push_back(lo);
            loadBytes.push_back(hi);
        end
        if (badTag >= 0) begin
            loadBytes.push_back(8'($urandom_range(0, 255)));
            loadBytes.push_back({4'(badTag), 4'($urandom_range(0, 15))});
        end
    endtask

    task automatic sendLoad(input int maxGap, input bit doStart, input int injectAt, input int tailStart);
        wrQ.delete();
        doneQ.delete();
        hiCyc.delete();
        if (doStart) applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < loadBytes.size(); i++) begin
            idle((i % 2 == 0 && i > 0) ? $urandom_range(1, maxGap) : $urandom_range(0, maxGap));
            if (i == injectAt) applyStimulus(1'b1, 1'b0, 8'h00);
            if (i % 2 == 1) hiCyc.push_back(cyc);
            applyStimulus(i == injectAt + 1, 1'b1, loadBytes[i]);
        end
        if (tailStart >= 0) begin
            idle(tailStart);
            applyStimulus(1'b1, 1'b0, 8'h00);
        end
        idle(4);
    endtask

    // Reference: pair k is written iff its high nibble equals k; the first bad tag ends the load.
    task automatic checkLoad(input string name);
        int  expN;
        bit  expErr;
        bit  expDone;
        int  lo, hi;
        expN   = 0;
        expErr = 1'b0;
        for (int k = 0; 2 * k + 1 < loadBytes.size(); k++) begin
            lo = int'(loadBytes[2 * k]);
            hi = int'(loadBytes[2 * k + 1]);
            if (hi / 16 != k) begin
                expErr = 1'b1;
                break;
            end
            if (expN < wrQ.size()) begin
                checkOutput($sformatf("%s addr%0d", name, k), wrQ[expN].addr, k);
                checkOutput($sformatf("%s data%0d", name, k), wrQ[expN].data, (hi % 16) * 256 + lo);
                checkOutput($sformatf("%s wrcyc%0d", name, k), wrQ[expN].cyc, hiCyc[k] + 1);
            end
            expN++;
        end
        expDone = !expErr && (expN == 16);
        checkOutput({name, " wrcount"}, wrQ.size(), expN);
        checkOutput({name, " donecount"}, doneQ.size(), expDone);
        if (expDone && doneQ.size() > 0) checkOutput({name, " donecyc"}, doneQ[0], hiCyc[15] + 2);
        checkOutput({name, " err"}, 32'(err), expErr);
        checkOutput({name, " en_fir"}, 32'(enFir), expDone);
        checkOutput({name, " busy"}, 32'(busy), 0);
    endtask

    initial begin
        int lowCyc;
        int nWr;
        rst          = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset, then 100 quiet cycles.
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst       = 1'b0;
        watchIdle = 1'b1;
        idle(100);
        watchIdle = 1'b0;
        checkOutput("idle nonzero", nonZeroCnt, 0);

        // Patterned full load; a start in the DONE cycle must be ignored.
        buildLoad(16, 1'b1, -1);
        sendLoad(3, 1'b1, -10, 1);
        checkLoad("pattern");

        // Random full load.
        buildLoad(16, 1'b0, -1);
        sendLoad(3, 1'b1, -10, -1);
        checkLoad("random");

        // Wrong tag on coef 3; a start in the ERR cycle must be ignored.
        buildLoad(3, 1'b0, 5);
        sendLoad(3, 1'b1, -10, 0);
        checkLoad("tagerr");

        // Bytes in IDLE are dropped and leave err set.
        wrQ.delete();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        idle(2);
        checkOutput("idlebytes wr", wrQ.size(), 0);
        checkOutput("idlebytes busy", 32'(busy), 0);
        checkOutput("idlebytes err", 32'(err), 1);

        // A new start clears err; starts mid-load are ignored.
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("restart err", 32'(err), 0);
        checkOutput("restart busy", 32'(busy), 1);
        buildLoad(16, 1'b0, -1);
        sendLoad(3, 1'b0, 9, -1);
        checkLoad("afterr");

        // Stall after one low byte: err appears 51 cycles after it.
        applyStimulus(1'b1, 1'b0, 8'h00);
        errRise = -1;
        wrQ.delete();
        lowCyc = cyc;
        applyStimulus(1'b0, 1'b1, 8'h5A);
        idle(60);
        checkOutput("timeout errcyc", errRise, lowCyc + 51);
        checkOutput("timeout busy", 32'(busy), 0);
        checkOutput("timeout en_fir", 32'(enFir), 0);
        checkOutput("timeout wr", wrQ.size(), 0);

        // A high byte in the last allowed cycle continues the load.
        applyStimulus(1'b1, 1'b0, 8'h00);
        wrQ.delete();
        lowCyc = cyc;
        applyStimulus(1'b0, 1'b1, 8'h3C);
        idle(TB_TIMEOUT - 1);
        applyStimulus(1'b0, 1'b1, 8'h0A);
        idle(2);
        checkOutput("edge50 wrcount", wrQ.size(), 1);
        if (wrQ.size() > 0) begin
            checkOutput("edge50 wrcyc", wrQ[0].cyc, lowCyc + 51);
            checkOutput("edge50 data", wrQ[0].data, 32'hA3C);
        end
        checkOutput("edge50 err", 32'(err), 0);
        checkOutput("edge50 busy", 32'(busy), 1);

        // Continue with coefs 1..6, then reset between the bytes of coef 7.
        for (int k = 1; k < 7; k++) begin
            applyStimulus(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
            applyStimulus(1'b0, 1'b1, {4'(k), 4'($urandom_range(0, 15))});
            idle($urandom_range(1, 3));
        end
        applyStimulus(1'b0, 1'b1, 8'h77);
        nWr = wrQ.size();
        checkOutput("midrst prewrites", nWr, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkAllZero("midrst");
        applyStimulus(1'b0, 1'b1, 8'h71);
        idle(5);
        checkOutput("midrst nowrite", wrQ.size(), nWr);
        checkAllZero("midrst after");

        // A fresh full load starts again at addr 0.
        buildLoad(16, 1'b0, -1);
        sendLoad(2, 1'b1, -10, -1);
        checkLoad("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coef_load_ctrl.md
# coef_load_ctrl

Sequencer that loads the FIR coefficient bank from the UART receive byte stream. It sits between the UART receiver and `block_coef`'s coefficient registers. It assembles 16 twelve-bit coefficients from byte pairs, checks the index tag and inter-byte timeout, and drives indexed writes into the bank. It holds the FIR enable low while the bank is being rewritten.

## Interface
- `N_COEF`, 16, number of coefficients per load (power of two, ≤16).
- `COEF_W`, 12, coefficient width; `COEF_W - 8` must be ≤4.
- `TIMEOUT_CYC`, 1_000_000, maximum idle cycles between bytes of one load (10 ms at 100 MHz).

- `clk_i`  in  1  system clock, 100 MHz.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  single-cycle pulse from the debounced `pulsador_carga_coef` that requests a new load.
- `rx_data_i`  in  8  received UART byte.
- `rx_valid_i`  in  1  one-cycle strobe; `rx_data_i` is valid in that cycle.
- `coef_wr_o`  out  1  write strobe to the coefficient bank.
- `coef_addr_o`  out  4  coefficient index being written.
- `coef_data_o`  out  COEF_W  coefficient value being written.
- `busy_o`  out  1  high while a load is in progress.
- `done_o`  out  1  one-cycle pulse when all `N_COEF` coefficients have been written.
- `err_o`  out  1  sticky error flag; cleared by the next accepted `start_i`.
- `en_fir_o`  out  1  FIR enable; low from reset and throughout any load, high only after a successful load.

## Operation
- States: IDLE, WAIT_LO, WAIT_HI, WRITE, DONE, ERR.
- IDLE → WAIT_LO on `start_i`. This clears `err_o` and `en_fir_o`, sets index to 0 and asserts `busy_o`.
- WAIT_LO: on `rx_valid_i`, latch `rx_data_i` as `coef[7:0]` and go to WAIT_HI.
- WAIT_HI: on `rx_valid_i`:
  - Bits [7:4] form the index tag and must equal the current index. Bits [COEF_W-9:0] supply `coef[COEF_W-1:8]`. Unused bits in [3:0] are ignored.
  - Tag match → WRITE.
  - Tag mismatch → ERR.
- WRITE (one cycle): assert `coef_wr_o` with `coef_addr_o` = index and `coef_data_o` = assembled value.
  - If index = `N_COEF-1` → DONE.
  - Otherwise increment index and go to WAIT_LO.
- DONE (one cycle): pulse `done_o`, set `en_fir_o`, drop `busy_o`, go to IDLE.
- ERR (one cycle): set `err_o`, drop `busy_o`, go to IDLE. `en_fir_o` stays low.
- Timeout: in WAIT_LO or WAIT_HI, if `TIMEOUT_CYC` cycles pass with no `rx_valid_i`, go to ERR.
- Coefficients already written before an error remain in the bank. The FIR stays disabled until a full load completes.

## Timing
- Reset value of every output is 0. The state after reset is IDLE.
- Write latency: `coef_wr_o` is high exactly one cycle after the cycle in which the high byte is accepted.
- `done_o` rises in the cycle after the last `coef_wr_o`. `en_fir_o` rises in the same cycle and `busy_o` falls in the same cycle.
- `coef_addr_o` and `coef_data_o` hold their last written values outside WRITE. They are only meaningful while `coef_wr_o` is high.
- `start_i` while `busy_o` is high: ignored.
- `start_i` in the same cycle as DONE or ERR: ignored. It is accepted only when the FSM is in IDLE.
- `rx_valid_i` in IDLE, WRITE, DONE or ERR: the byte is dropped and has no effect.
- Timeout counter:
  - Resets on entry to WAIT_LO/WAIT_HI and on every accepted byte.
  - If `rx_valid_i` arrives in the same cycle the counter reaches `TIMEOUT_CYC`, the byte wins and there is no error.
- `rst_i` mid-load: the FSM returns to IDLE next cycle with all outputs 0. No partial write is issued.

## Structure
- Shared package `coef_load_pkg`: the state enum, `N_COEF`, `COEF_W`, the tag field position [7:4], and the default `TIMEOUT_CYC`.
- Sub-module `byte_timeout`: a loadable down-counter with `clear_i`, `run_i` and `expired_o`, parameterised by `TIMEOUT_CYC`.
- The FSM, index counter and low-byte/assembly registers stay in the top module.

## Test plan
- Reset then idle: hold `rst_i` for 3 cycles. All outputs must be 0 and must stay 0 for 100 cycles with no stimulus.
- Full load: send `start_i`, then 32 bytes where coef k = 0x100·(k mod 16) + k, high byte = {k[3:0], k[3:0]}.
  - Required: 16 `coef_wr_o` pulses with addr 0..15 and the matching data.
  - Required: `done_o` pulses once, one cycle after write 15; `en_fir_o` = 1; `err_o` = 0.
- Tag mismatch: correct bytes for coefs 0–2, then a high byte with tag 5 for coef 3.
  - Required: exactly 3 writes, `err_o` = 1, `busy_o` = 0, `en_fir_o` = 0, no `done_o`.
- Timeout: set `TIMEOUT_CYC` = 50, send `start_i` and one low byte, then stall.
  - Required: `err_o` rises 51 cycles after the byte.
  - A byte at exactly cycle 50 must instead continue the load.
- Ignored events: `start_i` mid-load and `rx_valid_i` while in IDLE must not change index or state.
  - A second `start_i` after ERR clears `err_o` and a following full load succeeds.
- Reset mid-load: assert `rst_i` between the low and high byte of coef 7.
  - Required: no further `coef_wr_o` and all outputs 0.
  - A subsequent full load writes addr 0 first.
